// File: rtl/sap_pkg.sv
// ============================================================================
// Module  : sap_pkg
// Brief   : Shared widths and opcode encodings for the SAP-style 8-bit CPU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sap_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_OUT = 4'h4;
   localparam logic [3:0] OP_HLT = 4'hF;

endpackage

`default_nettype wire

// File: rtl/ld_reg.sv
// ============================================================================
// Module  : ld_reg
// Brief   : Width-parameterised register with synchronous reset and load.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ld_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else if (ld) begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/sap_core_regs.sv
// ============================================================================
// Module  : sap_core_regs
// Brief   : PC, IR and accumulator slice with split bus in/out and drive mux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sap_core_regs
   import sap_pkg::*;
#(
   parameter int DATA_W = sap_pkg::DATA_W,
   parameter int ADDR_W = sap_pkg::ADDR_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pc_en,
   input  logic                     pc_ld,
   input  logic                     pc_oe,
   input  logic                     ir_ld,
   input  logic                     ir_oe,
   input  logic                     a_ld,
   input  logic                     a_oe,
   input  logic [DATA_W-1:0]        bus_in,
   output logic [ADDR_W-1:0]        pc_q,
   output logic [DATA_W-ADDR_W-1:0] ir_opcode,
   output logic [ADDR_W-1:0]        ir_operand,
   output logic [DATA_W-1:0]        a_q,
   output logic [DATA_W-1:0]        bus_out,
   output logic                     bus_drive,
   output logic                     bus_conflict
);

   localparam int c_PAD_W = DATA_W - ADDR_W;

   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] w_ir;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_bus_out;

   // Load beats increment; the counter wraps naturally at 2**ADDR_W.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc <= '0;
      end else if (pc_ld) begin
         r_pc <= bus_in[ADDR_W-1:0];
      end else if (pc_en) begin
         r_pc <= r_pc + 1'b1;
      end
   end

   ld_reg #(.WIDTH(DATA_W)) u_ir (
      .clk   (clk),
      .reset (reset),
      .ld    (ir_ld),
      .d     (bus_in),
      .q     (w_ir)
   );

   ld_reg #(.WIDTH(DATA_W)) u_a (
      .clk   (clk),
      .reset (reset),
      .ld    (a_ld),
      .d     (bus_in),
      .q     (w_a)
   );

   // Fixed priority PC > IR > A keeps bus_out deterministic under contention.
   always_comb begin
      w_bus_out = '0;
      if (pc_oe) begin
         w_bus_out = {{c_PAD_W{1'b0}}, r_pc};
      end else if (ir_oe) begin
         w_bus_out = {{c_PAD_W{1'b0}}, w_ir[ADDR_W-1:0]};
      end else if (a_oe) begin
         w_bus_out = w_a;
      end
   end

   assign pc_q         = r_pc;
   assign ir_opcode    = w_ir[DATA_W-1:ADDR_W];
   assign ir_operand   = w_ir[ADDR_W-1:0];
   assign a_q          = w_a;
   assign bus_out      = w_bus_out;
   assign bus_drive    = pc_oe | ir_oe | a_oe;
   assign bus_conflict = (pc_oe & ir_oe) | (pc_oe & a_oe) | (ir_oe & a_oe);

endmodule

`default_nettype wire

// File: tb/tb_sap_core_regs.sv
// ============================================================================
// Module  : tb_sap_core_regs
// Brief   : Directed plus random stimulus against a behavioural register model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sap_core_regs;

   logic       clk = 1'b0;
   logic       reset, pc_en, pc_ld, pc_oe, ir_ld, ir_oe, a_ld, a_oe;
   logic [7:0] bus_in;
   logic [3:0] pc_q, ir_opcode, ir_operand;
   logic [7:0] a_q, bus_out;
   logic       bus_drive, bus_conflict;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state held as plain integers.
   int m_pc, m_ir, m_a;

   sap_core_regs dut (
      .clk          (clk),
      .reset        (reset),
      .pc_en        (pc_en),
      .pc_ld        (pc_ld),
      .pc_oe        (pc_oe),
      .ir_ld        (ir_ld),
      .ir_oe        (ir_oe),
      .a_ld         (a_ld),
      .a_oe         (a_oe),
      .bus_in       (bus_in),
      .pc_q         (pc_q),
      .ir_opcode    (ir_opcode),
      .ir_operand   (ir_operand),
      .a_q          (a_q),
      .bus_out      (bus_out),
      .bus_drive    (bus_drive),
      .bus_conflict (bus_conflict)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic check_all(input string tag);
      int drivers;
      int exp_out;
      drivers = int'(pc_oe) + int'(ir_oe) + int'(a_oe);
      if (pc_oe)      exp_out = m_pc;
      else if (ir_oe) exp_out = m_ir % 16;
      else if (a_oe)  exp_out = m_a;
      else            exp_out = 0;
      check({tag, ".pc_q"},         32'(pc_q),         32'(m_pc));
      check({tag, ".ir_opcode"},    32'(ir_opcode),    32'(m_ir / 16));
      check({tag, ".ir_operand"},   32'(ir_operand),   32'(m_ir % 16));
      check({tag, ".a_q"},          32'(a_q),          32'(m_a));
      check({tag, ".bus_out"},      32'(bus_out),      32'(exp_out));
      check({tag, ".bus_drive"},    32'(bus_drive),    32'(drivers > 0));
      check({tag, ".bus_conflict"}, 32'(bus_conflict), 32'(drivers >= 2));
   endtask

   task automatic model_edge();
      if (reset) begin
         m_pc = 0; m_ir = 0; m_a = 0;
      end else begin
         if (pc_ld)      m_pc = int'(bus_in) % 16;
         else if (pc_en) m_pc = (m_pc + 1) % 16;
         if (ir_ld) m_ir = int'(bus_in);
         if (a_ld)  m_a  = int'(bus_in);
      end
   endtask

   // Check combinational outputs, clock once, then check the new state.
   task automatic step(input string tag);
      #1 check_all({tag, ".pre"});
      @(posedge clk);
      model_edge();
      #1 check_all({tag, ".post"});
   endtask

   task automatic idle();
      reset = 0; pc_en = 0; pc_ld = 0; pc_oe = 0;
      ir_ld = 0; ir_oe = 0; a_ld = 0; a_oe = 0; bus_in = 8'h00;
   endtask

   initial begin
      idle();
      reset = 1;
      @(posedge clk);
      model_edge();
      #1 check_all("reset");
      check("reset.pc_const", 32'(pc_q), 32'h0);
      check("reset.a_const",  32'(a_q),  32'h00);

      idle();
      for (int i = 0; i < 3; i++) step("idle");
      check("idle.bus_out_const", 32'(bus_out), 32'h00);

      // Count and wrap from reset: 1..15, 0, 1
      pc_en = 1;
      for (int i = 0; i < 17; i++) begin
         step("count");
         check("count.pc_const", 32'(pc_q), 32'((i + 1) % 16));
      end
      pc_ld = 1; bus_in = 8'h5A;
      step("ld_wins");
      check("ld_wins.pc_const", 32'(pc_q), 32'hA);

      // Fetch / LDA sequence
      idle();
      bus_in = 8'h1E; ir_ld = 1;
      step("fetch");
      check("fetch.opcode_const",  32'(ir_opcode),  32'h1);
      check("fetch.operand_const", 32'(ir_operand), 32'hE);
      idle();
      ir_oe = 1; #1;
      check("ir_oe.bus_out_const", 32'(bus_out), 32'h0E);
      check("ir_oe.drive_const",   32'(bus_drive), 32'h1);
      ir_oe = 0; bus_in = 8'h2C; a_ld = 1;
      step("lda");
      check("lda.a_const", 32'(a_q), 32'h2C);

      // Accumulator drive
      idle(); a_oe = 1; #1;
      check("a_oe.bus_out_const", 32'(bus_out), 32'h2C);
      a_oe = 0; #1;
      check("a_idle.a_const",     32'(a_q), 32'h2C);
      check("a_idle.drive_const", 32'(bus_drive), 32'h0);

      // Contention with PC=3
      bus_in = 8'h03; pc_ld = 1;
      step("pc3");
      idle(); pc_oe = 1; a_oe = 1; #1;
      check("conf2.flag_const", 32'(bus_conflict), 32'h1);
      check("conf2.out_const",  32'(bus_out), 32'h03);
      ir_oe = 1;
      step("conf3");
      check("conf3.out_const", 32'(bus_out), 32'h03);

      // Self-loop: A captures bus_in, not its own value
      idle(); a_oe = 1; a_ld = 1; bus_in = 8'h77;
      step("selfloop");
      check("selfloop.a_const", 32'(a_q), 32'h77);

      // Reset overrides every load and increment
      idle(); reset = 1; pc_en = 1; ir_ld = 1; a_ld = 1; bus_in = 8'hFF;
      step("rst_prio");
      check("rst_prio.pc_const", 32'(pc_q), 32'h0);
      check("rst_prio.ir_const", 32'({ir_opcode, ir_operand}), 32'h00);
      check("rst_prio.a_const",  32'(a_q), 32'h00);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         reset  = ($urandom_range(0, 31) == 0);
         pc_en  = 1'($urandom);
         pc_ld  = ($urandom_range(0, 3) == 0);
         pc_oe  = ($urandom_range(0, 2) == 0);
         ir_ld  = ($urandom_range(0, 2) == 0);
         ir_oe  = ($urandom_range(0, 2) == 0);
         a_ld   = ($urandom_range(0, 2) == 0);
         a_oe   = ($urandom_range(0, 2) == 0);
         bus_in = 8'($urandom);
         step("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
